sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between three masters: memory initializer (MI), frame reader (FR) and fractal processor (PR).
- Replaces the combinational mux-select and yield logic.
- Changes ownership only on transaction boundaries, so a read burst or write never straddles two masters.
- FR has real-time priority over PR. A starvation guard bounds PR wait; a watchdog catches lost completions.

Parameters:
READ_BURST_LENGTH  8     data_read_valid beats per READ command
PR_MAX_WAIT        512   cycles PR may wait while FR owns before PR is forced one transaction
TIMEOUT            1023  max cycles a transaction may stay outstanding

Ports:
i_Clk                in   1   memory clock (MEM_CLK domain)
i_Rst_N              in   1   asynchronous active-low reset
i_SDRAM_Initialized  in   1   MI finished; level, stays high
i_MI_Command         in   2   MI command
i_MI_Data_Address    in   22  MI address
i_MI_Data_Write      in   32  MI write data
i_FR_Request         in   1   FR wants the bus (level)
i_FR_Command         in   2   FR command
i_FR_Data_Address    in   22  FR address
i_PR_Request         in   1   PR wants the bus (level)
i_PR_Command         in   2   PR command
i_PR_Data_Address    in   22  PR address
i_PR_Data_Write      in   32  PR write data
i_Data_Read_Valid    in   1   controller read beat
i_Data_Write_Done    in   1   controller write complete
o_FR_Grant           out  1   FR owns bus
o_PR_Grant           out  1   PR owns bus
o_Command            out  2   to controller
o_Data_Address       out  22  to controller
o_Data_Write         out  32  to controller
o_Owner              out  2   0=MI 1=FR 2=PR 3=none
o_Busy               out  1   transaction outstanding
o_Timeout_Error      out  1   sticky watchdog flag

Behaviour:
- Command encoding: 2'b00 NOP, 2'b01 READ, 2'b10 WRITE, 2'b11 treated as NOP (not forwarded).
- Reset (async, i_Rst_N low): state S_INIT; grants 0; o_Owner 0; o_Busy 0; o_Timeout_Error 0; beat counter, wait counter and watchdog 0.
- Outputs are a combinational mux on the registered owner. Owner none/drain forces o_Command=NOP, address 0, write data 0.

States:
- S_INIT: owner MI; MI signals pass through. On i_SDRAM_Initialized=1 and !o_Busy -> S_IDLE.
- S_IDLE: owner none.
  - FR request -> S_FR.
  - Else PR request -> S_PR.
  - Grant is asserted the cycle after request is seen (1-cycle latency).
- S_FR: o_FR_Grant=1.
  - FR request drops -> S_DRAIN.
  - PR wait counter reaches PR_MAX_WAIT and !o_Busy -> S_DRAIN, then S_PR (forced slot).
- S_PR: o_PR_Grant=1.
  - PR request drops -> S_DRAIN.
  - FR request high (preempt) -> S_DRAIN.
  - Forced slot ends after one completed transaction -> S_DRAIN.
- S_DRAIN: grants 0, NOP output. When !o_Busy:
  - -> S_PR if forced slot pending.
  - Else -> S_FR if FR request.
  - Else -> S_PR if PR request.
  - Else -> S_IDLE.
- Grant drops in the same cycle the state leaves S_FR/S_PR. Commands presented in that cycle are not forwarded.

Transaction tracking:
- Forwarded READ sets o_Busy the next cycle and loads the beat counter with READ_BURST_LENGTH. Each i_Data_Read_Valid decrements it; o_Busy clears the cycle after the last beat.
- Forwarded WRITE sets o_Busy; i_Data_Write_Done clears it.
- A command from the owner while o_Busy=1 is a master protocol violation. The arbiter forces NOP (not forwarded).
- A completion with o_Busy=0 is ignored.

PR wait counter:
- Increments while PR request=1 and owner≠PR; saturates at PR_MAX_WAIT.
- Clears when PR is granted or PR request=0.

Watchdog:
- Counts while o_Busy=1. On reaching TIMEOUT: clear o_Busy and beat counter, set o_Timeout_Error (sticky until reset), proceed as if complete.

Other rules:
- Simultaneous FR and PR requests in S_IDLE -> FR wins.
- Completion and new request in the same cycle: completion takes effect first; the switch happens that cycle.
- Reset mid-burst: all state cleared immediately; in-flight beats after reset are ignored (o_Busy=0).

Test Plan:
- Init pass-through: MI WRITE at address 0x000010, i_SDRAM_Initialized rises while o_Busy=1 -> o_Owner stays 0 until i_Data_Write_Done, then S_IDLE, o_Owner=3.
- FR/PR simultaneous: both requests high in S_IDLE -> o_FR_Grant=1 next cycle, o_PR_Grant=0; FR READ 0x000100 -> o_Busy=1 for exactly 8 beats.
- Preemption: PR owns, issues WRITE, FR requests -> o_PR_Grant drops next cycle; o_FR_Grant rises only the cycle after i_Data_Write_Done; no PR command reaches o_Command in between.
- Starvation: FR requests continuously, PR requests -> after 512 wait cycles and burst end, PR is granted for exactly one WRITE, then FR regains the bus.
- Watchdog: forward a READ, supply only 3 beats -> o_Busy clears at cycle 1023, o_Timeout_Error=1 and stays 1 until i_Rst_N low.
- Async reset mid-burst: i_Rst_N low during beat 4 -> grants, o_Busy=0 immediately; state S_INIT, o_Owner=0.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundle between the three SDRAM masters, the controller and the arbiter.
// slave  : arbiter side (master requests/commands and controller completions in, grants and controller command out)
// master : environment side (drives requests/commands/completions, observes grants and controller command)
interface sdram_arbiter_if;
    logic        i_SDRAM_Initialized;
    logic [1:0]  i_MI_Command;
    logic [21:0] i_MI_Data_Address;
    logic [31:0] i_MI_Data_Write;
    logic        i_FR_Request;
    logic [1:0]  i_FR_Command;
    logic [21:0] i_FR_Data_Address;
    logic        i_PR_Request;
    logic [1:0]  i_PR_Command;
    logic [21:0] i_PR_Data_Address;
    logic [31:0] i_PR_Data_Write;
    logic        i_Data_Read_Valid;
    logic        i_Data_Write_Done;
    logic        o_FR_Grant;
    logic        o_PR_Grant;
    logic [1:0]  o_Command;
    logic [21:0] o_Data_Address;
    logic [31:0] o_Data_Write;
    logic [1:0]  o_Owner;
    logic        o_Busy;
    logic        o_Timeout_Error;
    modport slave (
        input  i_SDRAM_Initialized, i_MI_Command, i_MI_Data_Address, i_MI_Data_Write,
               i_FR_Request, i_FR_Command, i_FR_Data_Address,
               i_PR_Request, i_PR_Command, i_PR_Data_Address, i_PR_Data_Write,
               i_Data_Read_Valid, i_Data_Write_Done,
        output o_FR_Grant, o_PR_Grant, o_Command, o_Data_Address, o_Data_Write,
               o_Owner, o_Busy, o_Timeout_Error
    );
    modport master (
        output i_SDRAM_Initialized, i_MI_Command, i_MI_Data_Address, i_MI_Data_Write,
               i_FR_Request, i_FR_Command, i_FR_Data_Address,
               i_PR_Request, i_PR_Command, i_PR_Data_Address, i_PR_Data_Write,
               i_Data_Read_Valid, i_Data_Write_Done,
        input  o_FR_Grant, o_PR_Grant, o_Command, o_Data_Address, o_Data_Write,
               o_Owner, o_Busy, o_Timeout_Error
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between memory initializer, frame reader and fractal processor.
// i_Clk   : memory clock
// i_Rst_N : asynchronous active-low reset
// bus     : sdram_arbiter_if.slave (master commands/requests, controller completions, grants, muxed command)
// Ownership changes only when no transaction is outstanding; FR beats PR, with a forced PR slot after PR_MAX_WAIT.
module sdram_arbiter #(
    parameter int unsigned READ_BURST_LENGTH = 8,
    parameter int unsigned PR_MAX_WAIT       = 512,
    parameter int unsigned TIMEOUT           = 1023
) (
    input logic           i_Clk,
    input logic           i_Rst_N,
    sdram_arbiter_if.slave bus
);
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_FR    = 3'd2;
    localparam logic [2:0] S_PR    = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [1:0] C_NOP   = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam int BW = $clog2(READ_BURST_LENGTH + 1);
    localparam int WW = $clog2(PR_MAX_WAIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]    state_q, state_d;
    logic          forced_q, forced_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [TW-1:0] wd_q, wd_d;
    logic [1:0]    owner, own_cmd;
    logic          timeout, done, free, fwd, fr, pr;

    assign fr      = bus.i_FR_Request;
    assign pr      = bus.i_PR_Request;
    assign owner   = state_q == S_INIT ? 2'd0 : state_q == S_FR ? 2'd1 : state_q == S_PR ? 2'd2 : 2'd3;
    assign own_cmd = owner == 2'd0 ? bus.i_MI_Command : owner == 2'd1 ? bus.i_FR_Command :
                     owner == 2'd2 ? bus.i_PR_Command : C_NOP;
    assign timeout = busy_q && wd_q == TW'(TIMEOUT - 1);
    // beat_q == 0 while busy means the outstanding transaction is a write
    assign done    = busy_q && (timeout || (beat_q == '0 ? bus.i_Data_Write_Done
                                                        : bus.i_Data_Read_Valid && beat_q == BW'(1)));
    // a completion in this cycle counts as already idle, so a switch can happen now
    assign free    = !busy_q || done;
    // nothing is forwarded while busy or in the cycle ownership is being handed over
    assign fwd     = !busy_q && state_d == state_q && (own_cmd == C_READ || own_cmd == C_WRITE);

    always_comb begin
        state_d  = state_q;
        forced_d = forced_q;
        case (state_q)
            S_INIT:  if (bus.i_SDRAM_Initialized && free) state_d = S_IDLE;
            S_IDLE:  state_d = fr ? S_FR : pr ? S_PR : S_IDLE;
            S_FR: begin
                if (!fr) state_d = S_DRAIN;
                else if (wait_q == WW'(PR_MAX_WAIT) && free) begin
                    state_d  = S_DRAIN;
                    forced_d = 1'b1;
                end
            end
            // a forced slot ignores FR preemption and ends after one completed transaction
            S_PR: begin
                if (!pr || (forced_q ? done : fr)) begin
                    state_d  = S_DRAIN;
                    forced_d = 1'b0;
                end
            end
            S_DRAIN: if (free) state_d = forced_q ? S_PR : fr ? S_FR : pr ? S_PR : S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        beat_d = beat_q;
        err_d  = err_q || timeout;
        wd_d   = busy_q && !done ? wd_q + 1'b1 : '0;
        wait_d = !pr || owner == 2'd2 ? '0 : wait_q == WW'(PR_MAX_WAIT) ? wait_q : wait_q + 1'b1;
        if (done) begin
            busy_d = 1'b0;
            beat_d = '0;
        end else if (busy_q && beat_q != '0 && bus.i_Data_Read_Valid) begin
            beat_d = beat_q - 1'b1;
        end
        if (fwd) begin
            busy_d = 1'b1;
            beat_d = own_cmd == C_READ ? BW'(READ_BURST_LENGTH) : '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            state_q  <= S_INIT;
            forced_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            beat_q   <= '0;
            wait_q   <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            forced_q <= forced_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            wd_q     <= wd_d;
        end
    end

    assign bus.o_FR_Grant      = state_q == S_FR;
    assign bus.o_PR_Grant      = state_q == S_PR;
    assign bus.o_Owner         = owner;
    assign bus.o_Busy          = busy_q;
    assign bus.o_Timeout_Error = err_q;
    assign bus.o_Command       = fwd ? own_cmd : C_NOP;
    assign bus.o_Data_Address  = owner == 2'd0 ? bus.i_MI_Data_Address : owner == 2'd1 ? bus.i_FR_Data_Address :
                                 owner == 2'd2 ? bus.i_PR_Data_Address : '0;
    assign bus.o_Data_Write    = owner == 2'd0 ? bus.i_MI_Data_Write : owner == 2'd2 ? bus.i_PR_Data_Write : '0;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: table-driven and directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;
    localparam logic [21:0] MI_A = 22'h000010;
    localparam logic [21:0] FR_A = 22'h000100;
    localparam logic [21:0] PR_A = 22'h000200;
    localparam logic [31:0] MI_D = 32'hA5A50001;
    localparam logic [31:0] PR_D = 32'hDEADBEEF;

    typedef struct {
        int init, mi_cmd, fr, fr_cmd, pr, pr_cmd, rv, wd;
        int e_own, e_frg, e_prg, e_cmd, e_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;
    vec_t tbl[26];

    always #5 clk = ~clk;

    sdram_arbiter_if bus();
    sdram_arbiter dut (.i_Clk(clk), .i_Rst_N(rst_n), .bus(bus));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] exp_addr(input int own);
        return own == 0 ? MI_A : own == 1 ? FR_A : own == 2 ? PR_A : 22'h0;
    endfunction

    function automatic logic [31:0] exp_data(input int own);
        return own == 0 ? MI_D : own == 2 ? PR_D : 32'h0;
    endfunction

    initial begin
        bus.i_SDRAM_Initialized = 1'b0;
        bus.i_MI_Command = 2'd0;
        bus.i_MI_Data_Address = MI_A;
        bus.i_MI_Data_Write = MI_D;
        bus.i_FR_Request = 1'b0;
        bus.i_FR_Command = 2'd0;
        bus.i_FR_Data_Address = FR_A;
        bus.i_PR_Request = 1'b0;
        bus.i_PR_Command = 2'd0;
        bus.i_PR_Data_Address = PR_A;
        bus.i_PR_Data_Write = PR_D;
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_Data_Write_Done = 1'b0;
        //          init mi fr fc pr pc rv wd | own frg prg cmd busy
        tbl[0]  = '{0, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
        tbl[2]  = '{1, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 1, 0, 1, 0, 0, 0,  3, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 1, 1, 1, 0, 0, 0,  1, 1, 0, 1, 0};
        tbl[7]  = '{1, 0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 1};
        tbl[8]  = '{1, 0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 1};
        tbl[9]  = '{1, 0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 1};
        tbl[10] = '{1, 0, 1, 1, 1, 0, 1, 0,  1, 1, 0, 0, 1};
        tbl[11] = '{1, 0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 1};
        tbl[12] = '{1, 0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 1};
        tbl[13] = '{1, 0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 1};
        tbl[14] = '{1, 0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 1};
        tbl[15] = '{1, 0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 0};
        tbl[16] = '{1, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0};
        tbl[17] = '{1, 0, 0, 0, 1, 0, 0, 0,  3, 0, 0, 0, 0};
        tbl[18] = '{1, 0, 0, 0, 1, 2, 0, 0,  2, 0, 1, 2, 0};
        tbl[19] = '{1, 0, 1, 0, 1, 2, 0, 0,  2, 0, 1, 0, 1};
        tbl[20] = '{1, 0, 1, 0, 1, 2, 0, 0,  3, 0, 0, 0, 1};
        tbl[21] = '{1, 0, 1, 0, 1, 0, 0, 1,  3, 0, 0, 0, 1};
        tbl[22] = '{1, 0, 1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0};
        tbl[23] = '{1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0};
        tbl[24] = '{1, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0};
        tbl[25] = '{1, 0, 0, 0, 0, 0, 0, 1,  3, 0, 0, 0, 0};

        repeat (2) step();
        chk("rst_owner", 32'(bus.o_Owner), 32'd0);
        chk("rst_fr_grant", 32'(bus.o_FR_Grant), 32'd0);
        chk("rst_pr_grant", 32'(bus.o_PR_Grant), 32'd0);
        chk("rst_busy", 32'(bus.o_Busy), 32'd0);
        chk("rst_timeout", 32'(bus.o_Timeout_Error), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            bus.i_SDRAM_Initialized = 1'(tbl[i].init);
            bus.i_MI_Command        = 2'(tbl[i].mi_cmd);
            bus.i_FR_Request        = 1'(tbl[i].fr);
            bus.i_FR_Command        = 2'(tbl[i].fr_cmd);
            bus.i_PR_Request        = 1'(tbl[i].pr);
            bus.i_PR_Command        = 2'(tbl[i].pr_cmd);
            bus.i_Data_Read_Valid   = 1'(tbl[i].rv);
            bus.i_Data_Write_Done   = 1'(tbl[i].wd);
            #1;
            chk($sformatf("row%0d_owner", i), 32'(bus.o_Owner), 32'(tbl[i].e_own));
            chk($sformatf("row%0d_fr_grant", i), 32'(bus.o_FR_Grant), 32'(tbl[i].e_frg));
            chk($sformatf("row%0d_pr_grant", i), 32'(bus.o_PR_Grant), 32'(tbl[i].e_prg));
            chk($sformatf("row%0d_command", i), 32'(bus.o_Command), 32'(tbl[i].e_cmd));
            chk($sformatf("row%0d_busy", i), 32'(bus.o_Busy), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d_addr", i), 32'(bus.o_Data_Address), 32'(exp_addr(tbl[i].e_own)));
            chk($sformatf("row%0d_wdata", i), bus.o_Data_Write, exp_data(tbl[i].e_own));
            step();
        end
        bus.i_Data_Write_Done = 1'b0;
        bus.i_Data_Read_Valid = 1'b0;

        // starvation guard: FR holds the bus, PR gets exactly one forced transaction
        bus.i_FR_Request = 1'b1;
        step();
        chk("starve_fr_owns", 32'(bus.o_FR_Grant), 32'd1);
        bus.i_PR_Request = 1'b1;
        n = 0;
        while (!bus.o_PR_Grant && n < 2000) begin
            step();
            n++;
        end
        chk("starve_wait_cycles", 32'(n), 32'd514);
        chk("starve_fr_dropped", 32'(bus.o_FR_Grant), 32'd0);
        bus.i_PR_Command = 2'd2;
        #1;
        chk("starve_pr_write", 32'(bus.o_Command), 32'd2);
        chk("starve_pr_data", bus.o_Data_Write, PR_D);
        step();
        bus.i_PR_Command = 2'd0;
        chk("starve_busy", 32'(bus.o_Busy), 32'd1);
        chk("starve_no_preempt", 32'(bus.o_PR_Grant), 32'd1);
        step();
        bus.i_Data_Write_Done = 1'b1;
        #1;
        chk("starve_hold_to_done", 32'(bus.o_PR_Grant), 32'd1);
        step();
        bus.i_Data_Write_Done = 1'b0;
        chk("starve_slot_end", 32'(bus.o_PR_Grant), 32'd0);
        chk("starve_drain_owner", 32'(bus.o_Owner), 32'd3);
        bus.i_PR_Request = 1'b0;
        step();
        chk("starve_fr_regain", 32'(bus.o_FR_Grant), 32'd1);

        // watchdog: READ with only 3 beats
        bus.i_FR_Command = 2'd1;
        #1;
        chk("wd_read_fwd", 32'(bus.o_Command), 32'd1);
        step();
        bus.i_FR_Command = 2'd0;
        n = 0;
        while (bus.o_Busy && n < 1100) begin
            bus.i_Data_Read_Valid = n < 3;
            step();
            n++;
        end
        bus.i_Data_Read_Valid = 1'b0;
        chk("wd_busy_cycles", 32'(n), 32'd1023);
        chk("wd_error_set", 32'(bus.o_Timeout_Error), 32'd1);
        repeat (5) step();
        chk("wd_error_sticky", 32'(bus.o_Timeout_Error), 32'd1);
        chk("wd_busy_low", 32'(bus.o_Busy), 32'd0);

        // async reset during beat 4 of a burst
        bus.i_FR_Command = 2'd1;
        step();
        bus.i_FR_Command = 2'd0;
        bus.i_Data_Read_Valid = 1'b1;
        repeat (3) step();
        chk("ar_busy_before", 32'(bus.o_Busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_fr_grant", 32'(bus.o_FR_Grant), 32'd0);
        chk("ar_pr_grant", 32'(bus.o_PR_Grant), 32'd0);
        chk("ar_busy", 32'(bus.o_Busy), 32'd0);
        chk("ar_owner", 32'(bus.o_Owner), 32'd0);
        chk("ar_timeout_clr", 32'(bus.o_Timeout_Error), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("ar_beats_ignored", 32'(bus.o_Busy), 32'd0);
        step();
        bus.i_Data_Read_Valid = 1'b0;
        chk("ar_stray_beat_idle", 32'(bus.o_Busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
